soc_test_monitor: RTL and testbench

Parametrised, synthesizable end-of-test monitor for the rv32i_soc simulation and FPGA bring-up flows. Snoops the core's Wishbone data-memory port and detects test completion from a write to a TOHOST mailbox address. Enforces a programmable cycle timeout, and captures writes into a configurable signature window into a small FIFO for later readout. Replaces fixed-length run-then-dump benches with a pass/fail/timeout verdict that benches and on-board logic can consume directly.

---
 rtl/soc_test_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_soc_test_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_test_monitor.sv
// soc_test_monitor: end-of-test monitor for the rv32i_soc data-memory Wishbone port.
//
// Snoops acked write beats and produces a verdict:
//   - a write of 1 to TOHOST_ADDR       -> PASS
//   - an odd write other than 1         -> FAIL, o_exit_code = data >> 1
//   - an even write to TOHOST_ADDR      -> ignored, test keeps running
//   - TIMEOUT_CYCLES cycles in RUN      -> TIMEOUT
// PASS, FAIL and TIMEOUT hold until reset. A tohost write in the final
// timeout cycle wins over the timeout.
//
// With SOC_MON_SIG_FIFO_EN defined, writes into [SIG_BASE, SIG_LIMIT) made
// while in RUN are pushed into a first-word fall-through FIFO of SIG_DEPTH
// entries. Without it no storage is built: o_sig_empty reads 1, the other
// signature outputs read 0 and i_sig_rd is ignored.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/ack     snooped handshake; a write beat needs all four high
//   i_wb_adr, i_wb_dat      snooped address and write data
//   o_done/o_pass/o_timeout verdict flags
//   o_exit_code             captured tohost value >> 1
//   o_cycle_count           RUN cycles elapsed, saturating, frozen once terminal
//   i_sig_rd                pop the signature FIFO head
//   o_sig_empty             FIFO empty
//   o_sig_addr/o_sig_data   head entry, 0 when empty
//   o_sig_overflow          sticky: a signature write was dropped
module soc_test_monitor #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter int unsigned       TIMEOUT_CYCLES = 10000,
    parameter logic [ADDR_W-1:0] SIG_BASE       = ADDR_W'(32'h0000_2000),
    parameter logic [ADDR_W-1:0] SIG_LIMIT      = ADDR_W'(32'h0000_2100),
    parameter int unsigned       SIG_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic              i_wb_ack,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [DATA_W-1:0] i_wb_dat,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_exit_code,
    output logic [31:0]       o_cycle_count,
    input  logic              i_sig_rd,
    output logic              o_sig_empty,
    output logic [ADDR_W-1:0] o_sig_addr,
    output logic [DATA_W-1:0] o_sig_data,
    output logic              o_sig_overflow
);

    typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [DATA_W-1:0] exit_q, exit_d;
    logic              done_q, pass_q, timeout_q;

    logic wr_beat;
    logic tohost_wr;

    assign wr_beat   = i_wb_cyc & i_wb_stb & i_wb_we & i_wb_ack;
    assign tohost_wr = wr_beat && (i_wb_adr == TOHOST_ADDR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        exit_d  = exit_q;
        case (state_q)
            StRun: begin
                if (count_q != 32'hFFFF_FFFF) begin
                    count_d = count_q + 32'd1;
                end
                if (tohost_wr && (i_wb_dat == DATA_W'(1))) begin
                    state_d = StPass;
                    exit_d  = i_wb_dat >> 1;
                end else if (tohost_wr && i_wb_dat[0]) begin
                    state_d = StFail;
                    exit_d  = i_wb_dat >> 1;
                end else if (count_q == TimeoutLast) begin
                    state_d = StTimeout;
                end
            end
            default: begin
                // Terminal states hold everything until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRun;
            count_q   <= '0;
            exit_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            exit_q    <= exit_d;
            // Flags registered from the next state so they are true flops.
            done_q    <= (state_d != StRun);
            pass_q    <= (state_d == StPass);
            timeout_q <= (state_d == StTimeout);
        end
    end

    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_timeout     = timeout_q;
    assign o_exit_code   = exit_q;
    assign o_cycle_count = count_q;

`ifdef SOC_MON_SIG_FIFO_EN
    localparam int unsigned PtrW = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1;

    logic [ADDR_W-1:0] addr_mem_q [SIG_DEPTH];
    logic [DATA_W-1:0] data_mem_q [SIG_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     cnt_q, cnt_d;
    logic              empty_q, ovf_q, ovf_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;

    logic in_window, push_req, push_ok, pop, full;

    assign in_window = (i_wb_adr >= SIG_BASE) && (i_wb_adr < SIG_LIMIT);
    assign push_req  = (state_q == StRun) && wr_beat && !tohost_wr && in_window;
    assign full      = (cnt_q == (PtrW + 1)'(SIG_DEPTH));
    assign pop       = i_sig_rd && (cnt_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        head_addr_d = '0;
        head_data_d = '0;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + (PtrW + 1)'(1);
        end else if (pop && !push_ok) begin
            cnt_d = cnt_q - (PtrW + 1)'(1);
        end
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        // Registered head: when the new head is the slot being written this
        // cycle, take it from the bus since the memory is not updated yet.
        if (cnt_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                head_addr_d = i_wb_adr;
                head_data_d = i_wb_dat;
            end else begin
                head_addr_d = addr_mem_q[rd_ptr_d];
                head_data_d = data_mem_q[rd_ptr_d];
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem_q[wr_ptr_q] <= i_wb_adr;
            data_mem_q[wr_ptr_q] <= i_wb_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            head_addr_q <= '0;
            head_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            empty_q     <= (cnt_d == '0);
            ovf_q       <= ovf_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
        end
    end

    assign o_sig_empty    = empty_q;
    assign o_sig_addr     = head_addr_q;
    assign o_sig_data     = head_data_q;
    assign o_sig_overflow = ovf_q;
`else
    localparam logic [ADDR_W-1:0] unused_sig_span  = SIG_LIMIT - SIG_BASE;
    localparam int unsigned       unused_sig_depth = SIG_DEPTH;

    logic unused_sig_rd;
    assign unused_sig_rd = i_sig_rd;

    assign o_sig_empty    = 1'b1;
    assign o_sig_addr     = '0;
    assign o_sig_data     = '0;
    assign o_sig_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed bench for soc_test_monitor with a queue-based reference model and
// a compare process that checks every output on each falling clock edge.
module tb_soc_test_monitor;

    localparam int unsigned T = 100;
    localparam int unsigned D = 4;
    localparam logic [31:0] TLast = 32'd99;
`ifdef SOC_MON_SIG_FIFO_EN
    localparam bit FifoEn = 1'b1;
`else
    localparam bit FifoEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack = 1'b0, sig_rd = 1'b0;
    logic [31:0] adr = '0, dat = '0;

    logic        o_done, o_pass, o_timeout, o_sig_empty, o_sig_overflow;
    logic [31:0] o_exit_code, o_cycle_count, o_sig_addr, o_sig_data;

    soc_test_monitor #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TOHOST_ADDR   (32'h0000_1000),
        .TIMEOUT_CYCLES(T),
        .SIG_BASE      (32'h0000_2000),
        .SIG_LIMIT     (32'h0000_2100),
        .SIG_DEPTH     (D)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_wb_cyc      (cyc),
        .i_wb_stb      (stb),
        .i_wb_we       (we),
        .i_wb_ack      (ack),
        .i_wb_adr      (adr),
        .i_wb_dat      (dat),
        .o_done        (o_done),
        .o_pass        (o_pass),
        .o_timeout     (o_timeout),
        .o_exit_code   (o_exit_code),
        .o_cycle_count (o_cycle_count),
        .i_sig_rd      (sig_rd),
        .o_sig_empty   (o_sig_empty),
        .o_sig_addr    (o_sig_addr),
        .o_sig_data    (o_sig_data),
        .o_sig_overflow(o_sig_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = running, 1 = pass, 2 = fail, 3 = timeout.
    int          m_state = 0;
    logic [31:0] m_count = '0;
    logic [31:0] m_exit = '0;
    logic [63:0] m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_wr, m_th, m_push;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_state = 0;
            m_count = '0;
            m_exit  = '0;
            m_ovf   = 1'b0;
            m_q.delete();
        end else begin
            m_wr   = cyc && stb && we && ack;
            m_th   = m_wr && (adr == 32'h0000_1000);
            m_push = FifoEn && (m_state == 0) && m_wr && !m_th &&
                     (adr >= 32'h0000_2000) && (adr < 32'h0000_2100);
            if (FifoEn && sig_rd && (m_q.size() > 0)) void'(m_q.pop_front());
            if (m_push) begin
                if (m_q.size() < D) m_q.push_back({adr, dat});
                else m_ovf = 1'b1;
            end
            if (m_state == 0) begin
                if (m_th && (dat == 32'd1)) begin
                    m_state = 1;
                    m_exit  = dat >> 1;
                end else if (m_th && dat[0]) begin
                    m_state = 2;
                    m_exit  = dat >> 1;
                end else if (m_count == TLast) begin
                    m_state = 3;
                end
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("done", 64'(o_done), 64'(m_state != 0));
        check("pass", 64'(o_pass), 64'(m_state == 1));
        check("timeout", 64'(o_timeout), 64'(m_state == 3));
        check("exit_code", 64'(o_exit_code), 64'(m_exit));
        check("cycle_count", 64'(o_cycle_count), 64'(m_count));
        check("sig_empty", 64'(o_sig_empty), 64'(m_q.size() == 0));
        check("sig_addr", 64'(o_sig_addr), (m_q.size() > 0) ? 64'(m_q[0][63:32]) : 64'd0);
        check("sig_data", 64'(o_sig_data), (m_q.size() > 0) ? 64'(m_q[0][31:0]) : 64'd0);
        check("sig_overflow", 64'(o_sig_overflow), 64'(m_ovf));
    end

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic ak);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; ack = ak; adr = a; dat = d;
        @(posedge clk);
        #2;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0;
    endtask

    task automatic pop();
        sig_rd = 1'b1;
        @(posedge clk);
        #2;
        sig_rd = 1'b0;
    endtask

    initial begin
        // Reset state and PASS at cycle 50.
        do_reset();
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_count", 64'(o_cycle_count), 64'd0);
        check("rst_empty", 64'(o_sig_empty), 64'd1);
        idle(50);
        wb_wr(32'h1000, 32'h1, 1'b1);
        check("pass_done", 64'(o_done), 64'd1);
        check("pass_pass", 64'(o_pass), 64'd1);
        check("pass_exit", 64'(o_exit_code), 64'd0);
        check("pass_count", 64'(o_cycle_count), 64'd51);
        idle(5);
        check("pass_count_frozen", 64'(o_cycle_count), 64'd51);
        wb_wr(32'h2000, 32'hAA, 1'b1);  // terminal state: not captured
        idle(1);

        // FAIL with exit code 3; later PASS write ignored.
        do_reset();
        idle(3);
        wb_wr(32'h1000, 32'h7, 1'b1);
        check("fail_done", 64'(o_done), 64'd1);
        check("fail_pass", 64'(o_pass), 64'd0);
        check("fail_timeout", 64'(o_timeout), 64'd0);
        check("fail_exit", 64'(o_exit_code), 64'd3);
        wb_wr(32'h1000, 32'h1, 1'b1);
        check("fail_sticky_pass", 64'(o_pass), 64'd0);
        check("fail_sticky_exit", 64'(o_exit_code), 64'd3);

        // Timeout after the 100th RUN edge.
        do_reset();
        idle(99);
        check("to_before", 64'(o_timeout), 64'd0);
        check("to_before_count", 64'(o_cycle_count), 64'd99);
        idle(1);
        check("to_after", 64'(o_timeout), 64'd1);
        check("to_after_done", 64'(o_done), 64'd1);
        check("to_after_count", 64'(o_cycle_count), 64'd100);
        idle(3);
        check("to_count_frozen", 64'(o_cycle_count), 64'd100);

        // Tohost write in the final timeout cycle wins.
        do_reset();
        idle(99);
        wb_wr(32'h1000, 32'h1, 1'b1);
        check("race_pass", 64'(o_pass), 64'd1);
        check("race_timeout", 64'(o_timeout), 64'd0);
        check("race_count", 64'(o_cycle_count), 64'd100);

        // Even tohost data and non-acked writes are ignored.
        do_reset();
        wb_wr(32'h1000, 32'h2, 1'b1);
        wb_wr(32'h1000, 32'h5, 1'b0);
        idle(2);
        check("even_done", 64'(o_done), 64'd0);

        // Six window writes into a 4-deep FIFO, then drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wb_wr(32'h2000 + 32'(4 * i), 32'h2000 + 32'(4 * i), 1'b1);
        end
`ifdef SOC_MON_SIG_FIFO_EN
        check("ovf_set", 64'(o_sig_overflow), 64'd1);
        check("fifo_nonempty", 64'(o_sig_empty), 64'd0);
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef SOC_MON_SIG_FIFO_EN
            check("drain_addr", 64'(o_sig_addr), 64'(32'h2000 + 32'(4 * i)));
            check("drain_data", 64'(o_sig_data), 64'(32'h2000 + 32'(4 * i)));
`endif
            pop();
        end
        check("drain_empty", 64'(o_sig_empty), 64'd1);
        check("drain_addr_zero", 64'(o_sig_addr), 64'd0);
        pop();  // pop while empty: no effect
        wb_wr(32'h2004, 32'h55, 1'b0);
        wb_wr(32'h2100, 32'h66, 1'b1);
        idle(1);
        check("no_capture_empty", 64'(o_sig_empty), 64'd1);

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wb_wr(32'h2010 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
        end
        sig_rd = 1'b1;
        wb_wr(32'h2040, 32'hBEEF, 1'b1);
        sig_rd = 1'b0;
        check("pp_ovf", 64'(o_sig_overflow), 64'd0);
`ifdef SOC_MON_SIG_FIFO_EN
        check("pp_head", 64'(o_sig_addr), 64'h2014);
        for (int i = 0; i < 3; i++) pop();
        check("pp_last_addr", 64'(o_sig_addr), 64'h2040);
        check("pp_last_data", 64'(o_sig_data), 64'hBEEF);
        pop();
        check("pp_empty", 64'(o_sig_empty), 64'd1);
`endif

        // Reset asserted mid-stream clears everything immediately.
        do_reset();
        wb_wr(32'h2000, 32'h11, 1'b1);
        wb_wr(32'h2004, 32'h22, 1'b1);
        idle(3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(o_cycle_count), 64'd0);
        check("mid_rst_done", 64'(o_done), 64'd0);
        check("mid_rst_empty", 64'(o_sig_empty), 64'd1);
        check("mid_rst_addr", 64'(o_sig_addr), 64'd0);
        check("mid_rst_data", 64'(o_sig_data), 64'd0);
        check("mid_rst_ovf", 64'(o_sig_overflow), 64'd0);
        idle(2);
        reset_n = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
